cla8_launch_capture: RTL and testbench
======================================

Name: cla8_launch_capture

Overview:
Sequential harness controller that sits in front of the gate-level, delay-annotated 8-bit carry-lookahead adder. It accepts operands over a valid/ready handshake and launches them onto the combinational CLA inputs. It waits a programmable number of settle cycles for gate propagation, then captures sum/carry and checks them against a behavioural golden result. The result is presented over a valid/ready output handshake with a mismatch flag and a saturating error counter.

Parameters:
WIDTH, 8, operand/sum width in bits
SETTLE_CYCLES, 4, clock edges between launch and capture; legal range 1..255
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in
cla_a  out  WIDTH  registered operand A driven to CLA
cla_b  out  WIDTH  registered operand B driven to CLA
cla_cin  out  1  registered carry-in driven to CLA
cla_sum  in  WIDTH  CLA sum output (combinational, delayed)
cla_cout  in  1  CLA carry-out
out_valid  out  1  captured result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  captured sum
out_cout  out  1  captured carry-out
out_err  out  1  captured {cout,sum} differs from golden
err_count  out  ERR_CNT_W  saturating count of mismatches since reset

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; cla_a/cla_b/cla_cin=0; out_valid=0; out_sum/out_cout/out_err=0; err_count=0; settle counter=0. Reset aborts any in-flight operation. No partial result is emitted.
- in_ready = (state==IDLE), combinational from state only. It never depends on in_valid.
- States: IDLE, SETTLE, HOLD.
- IDLE: on in_valid&&in_ready at edge T: cla_* <= in_*; golden <= in_a+in_b+in_cin, computed WIDTH+1 bits wide with zero-extension; counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: the counter decrements each edge. At the edge where counter==0 (edge T+SETTLE_CYCLES):
  - out_sum<=cla_sum, out_cout<=cla_cout
  - out_err <= ({cla_cout,cla_sum} != golden)
  - err_count increments if mismatch, saturating at all-ones
  - out_valid<=1; go to HOLD.
  - SETTLE_CYCLES=1 captures at T+1.
- HOLD: out_* and out_valid stable while out_ready=0. On out_valid&&out_ready at an edge: out_valid<=0, go to IDLE. out_sum/out_cout/out_err keep their last values.
- cla_* hold the last launched operands in all states until the next accept. They never return to 0 except on reset, so the CLA does not glitch between operations.
- in_valid is ignored outside IDLE. There is no operand buffering.
- Throughput with out_ready tied high: one transaction per SETTLE_CYCLES+2 cycles.
- Counter width: $clog2(SETTLE_CYCLES+1), minimum 1 bit.
- Unknown (X) on cla_sum/cla_cout at capture is a wiring or settle-time error. The verification bench must flag it.

Decomposition:
- Shared package cla8_pkg:
  - CLA_WIDTH=8
  - DEFAULT_SETTLE=4
  - state enum typedef (IDLE, SETTLE, HOLD)
  - typedef for the WIDTH+1 golden result
- Sub-module settle_timer: loadable down-counter with a done pulse, parameterised by SETTLE_CYCLES. The main FSM, capture and check logic stay in cla8_launch_capture.

Test Plan:
- SETTLE_CYCLES=4, bench connects the real CLA. Accept a=0x7F, b=0x01, cin=0 at edge T -> in_ready=0 for T..T+4; out_valid rises after edge T+4; out_sum=0x80, out_cout=0, out_err=0.
- Full carry ripple: a=0xFF, b=0x00, cin=1 -> out_sum=0x00, out_cout=1, out_err=0. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Fault injection: bench CLA model returns sum^0x01 -> out_err=1, err_count increments by 1 per transaction. 300 faulty transactions -> err_count=0xFF and stays there.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD and toggle in_valid with new operands -> out_* and cla_* stable, in_ready=0, no second accept. Releasing out_ready -> in_ready=1 the next cycle.
- Reset mid-operation: assert rst for one edge at the 2nd SETTLE cycle -> after that edge all outputs are 0, state is IDLE, in_ready=1, no out_valid pulse ever appears for the aborted operands.
- Throughput, SETTLE_CYCLES=1 and 4, out_ready=1, in_valid=1 continuous: accepts spaced exactly 3 and 6 cycles apart. 256 random operand pairs give 0 mismatches against the real CLA.

Source files
------------

// File: rtl/cla8_pkg.sv
// Shared types and defaults for the CLA launch/capture harness.
package cla8_pkg;

  localparam int unsigned CLA_WIDTH      = 8;
  localparam int unsigned DEFAULT_SETTLE = 4;

  // Controller phases: waiting for operands, waiting for gate settle, presenting result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Behavioural golden result: {carry, sum}.
  typedef logic [CLA_WIDTH:0] golden_t;

endpackage

// File: rtl/cla8_launch_capture_settle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count;

  // Load on launch, then count down to zero while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/cla8_launch_capture.sv
// Launches operands onto an external delay-annotated CLA, waits a fixed
// settle time, captures the result and checks it against a golden sum.
module cla8_launch_capture
  import cla8_pkg::*;
#(
  parameter int unsigned WIDTH         = CLA_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  output logic [WIDTH-1:0]     cla_a,
  output logic [WIDTH-1:0]     cla_b,
  output logic                 cla_cin,
  input  logic [WIDTH-1:0]     cla_sum,
  input  logic                 cla_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t         state;
  logic [WIDTH:0] golden;
  logic           timer_load;
  logic           timer_en;
  logic           timer_done;
  logic           mismatch;

  assign in_ready   = (state == IDLE);
  assign timer_load = (state == IDLE) && in_valid;
  assign timer_en   = (state == SETTLE);
  assign mismatch   = ({cla_cout, cla_sum} != golden);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .done (timer_done)
  );

  // Handshake FSM with launch, capture/check and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cla_a     <= '0;
      cla_b     <= '0;
      cla_cin   <= 1'b0;
      golden    <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cla_a   <= in_a;
            cla_b   <= in_b;
            cla_cin <= in_cin;
            golden  <= (WIDTH+1)'(in_a) + (WIDTH+1)'(in_b) + (WIDTH+1)'(in_cin);
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_done) begin
            out_sum   <= cla_sum;
            out_cout  <= cla_cout;
            out_err   <= mismatch;
            out_valid <= 1'b1;
            if (mismatch && (err_count != '1)) begin
              err_count <= err_count + ERR_CNT_W'(1);
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla8_launch_capture.sv
// Bench: two harness instances (settle 4 and settle 1) each driving a
// behavioural CLA with optional sum-LSB fault injection.
module tb_cla8_launch_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_a      [2];
  logic [7:0] in_b      [2];
  logic       in_cin    [2];
  logic [7:0] cla_a     [2];
  logic [7:0] cla_b     [2];
  logic       cla_cin   [2];
  logic [7:0] cla_sum   [2];
  logic       cla_cout  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_sum   [2];
  logic       out_cout  [2];
  logic       out_err   [2];
  logic [7:0] err_count [2];
  logic       fault     [2];

  int total = 0;
  int bad   = 0;
  int errm  [2];
  int settle [2];

  always #5 clk = ~clk;

  function automatic logic [8:0] cla_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic f);
    int s;
    s = int'(a) + int'(b) + int'(c);
    if (f) s = s ^ 1;
    return 9'(s);
  endfunction

  assign {cla_cout[0], cla_sum[0]} = cla_ref(cla_a[0], cla_b[0], cla_cin[0], fault[0]);
  assign {cla_cout[1], cla_sum[1]} = cla_ref(cla_a[1], cla_b[1], cla_cin[1], fault[1]);

  cla8_launch_capture #(.WIDTH(8), .SETTLE_CYCLES(4), .ERR_CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]),
    .cla_a(cla_a[0]), .cla_b(cla_b[0]), .cla_cin(cla_cin[0]),
    .cla_sum(cla_sum[0]), .cla_cout(cla_cout[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
    .out_cout(out_cout[0]), .out_err(out_err[0]), .err_count(err_count[0]));

  cla8_launch_capture #(.WIDTH(8), .SETTLE_CYCLES(1), .ERR_CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]),
    .cla_a(cla_a[1]), .cla_b(cla_b[1]), .cla_cin(cla_cin[1]),
    .cla_sum(cla_sum[1]), .cla_cout(cla_cout[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1]),
    .out_cout(out_cout[1]), .out_err(out_err[1]), .err_count(err_count[1]));

  // X on a captured value never matches, so unknowns are reported too.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input int d);
    check("rst_in_ready", 32'(in_ready[d]), 1);
    check("rst_cla_a", 32'(cla_a[d]), 0);
    check("rst_cla_b", 32'(cla_b[d]), 0);
    check("rst_cla_cin", 32'(cla_cin[d]), 0);
    check("rst_out_valid", 32'(out_valid[d]), 0);
    check("rst_out_sum", 32'(out_sum[d]), 0);
    check("rst_out_cout", 32'(out_cout[d]), 0);
    check("rst_out_err", 32'(out_err[d]), 0);
    check("rst_err_count", 32'(err_count[d]), 0);
  endtask

  // One directed transaction with exact latency and optional backpressure.
  task automatic txn(input int d, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input int hold);
    int k;
    int s;
    logic e;
    k = 0;
    while (!in_ready[d] && k < 50) begin
      tick();
      k++;
    end
    check("ready_wait", 32'(in_ready[d]), 1);
    in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b; in_cin[d] = c;
    tick();
    in_valid[d] = 1'b0;
    check("launch_a", 32'(cla_a[d]), 32'(a));
    check("launch_b", 32'(cla_b[d]), 32'(b));
    check("launch_cin", 32'(cla_cin[d]), 32'(c));
    check("busy_ready", 32'(in_ready[d]), 0);
    for (int i = 1; i < settle[d]; i++) begin
      tick();
      check("settle_valid", 32'(out_valid[d]), 0);
      check("settle_ready", 32'(in_ready[d]), 0);
    end
    tick();
    s = int'(a) + int'(b) + int'(c);
    if (fault[d]) s = s ^ 1;
    e = fault[d];
    if (e && errm[d] < 255) errm[d]++;
    check("cap_valid", 32'(out_valid[d]), 1);
    check("cap_sum", 32'(out_sum[d]), s & 255);
    check("cap_cout", 32'(out_cout[d]), (s >> 8) & 1);
    check("cap_err", 32'(out_err[d]), 32'(e));
    check("cap_errcnt", 32'(err_count[d]), errm[d]);
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = i[0];
      in_a[d] = 8'($urandom); in_b[d] = 8'($urandom); in_cin[d] = 1'($urandom);
      tick();
      check("hold_valid", 32'(out_valid[d]), 1);
      check("hold_ready", 32'(in_ready[d]), 0);
      check("hold_sum", 32'(out_sum[d]), s & 255);
      check("hold_cla_a", 32'(cla_a[d]), 32'(a));
      check("hold_cla_b", 32'(cla_b[d]), 32'(b));
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check("rel_valid", 32'(out_valid[d]), 0);
    check("rel_ready", 32'(in_ready[d]), 1);
    check("rel_sum_kept", 32'(out_sum[d]), s & 255);
    check("rel_cla_kept", 32'(cla_a[d]), 32'(a));
  endtask

  // Back-to-back random stream: checks accept spacing and in-order results.
  task automatic stream(input int d, input int n);
    int q[$];
    int last, cyc, acc, got, s, exp, limit;
    logic r;
    last = -1; cyc = 0; acc = 0; got = 0;
    limit = n * (settle[d] + 2) + 50;
    out_ready[d] = 1'b1;
    in_valid[d] = 1'b1;
    in_a[d] = 8'($urandom); in_b[d] = 8'($urandom); in_cin[d] = 1'($urandom);
    while ((acc < n || got < n) && cyc < limit) begin
      r = in_ready[d] && in_valid[d];
      @(posedge clk);
      cyc++;
      if (r) begin
        if (last >= 0) check("accept_gap", 32'(cyc - last), 32'(settle[d] + 2));
        last = cyc;
        q.push_back(int'(in_a[d]) + int'(in_b[d]) + int'(in_cin[d]));
        acc++;
      end
      #1;
      if (r) begin
        in_a[d] = 8'($urandom); in_b[d] = 8'($urandom); in_cin[d] = 1'($urandom);
        if (acc == n) in_valid[d] = 1'b0;
      end
      if (out_valid[d]) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid[d]), 0);
        end else begin
          s = q.pop_front();
          exp = fault[d] ? (s ^ 1) : s;
          if (fault[d] && errm[d] < 255) errm[d]++;
          check("str_sum", 32'(out_sum[d]), exp & 255);
          check("str_cout", 32'(out_cout[d]), (exp >> 8) & 1);
          check("str_err", 32'(out_err[d]), 32'(fault[d]));
          check("str_errcnt", 32'(err_count[d]), errm[d]);
          got++;
        end
      end
    end
    check("stream_count", 32'(got), 32'(n));
    tick();
    out_ready[d] = 1'b0;
    in_valid[d] = 1'b0;
  endtask

  initial begin
    settle[0] = 4; settle[1] = 1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; in_cin[d] = 1'b0;
      out_ready[d] = 1'b0; fault[d] = 1'b0; errm[d] = 0;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_state(0);
    check_reset_state(1);

    txn(0, 8'h7F, 8'h01, 1'b0, 0);
    txn(0, 8'hFF, 8'h00, 1'b1, 10);
    txn(0, 8'hFF, 8'hFF, 1'b1, 3);
    txn(1, 8'h80, 8'h80, 1'b0, 2);
    txn(1, 8'h00, 8'h00, 1'b0, 0);

    fault[0] = 1'b1;
    txn(0, 8'h12, 8'h34, 1'b0, 0);
    stream(0, 300);
    check("sat_errcnt", 32'(err_count[0]), 255);
    txn(0, 8'hA5, 8'h5A, 1'b1, 0);
    check("sat_stays", 32'(err_count[0]), 255);
    fault[0] = 1'b0;

    // Abort in the second settle cycle; nothing may be emitted afterwards.
    in_valid[0] = 1'b1; in_a[0] = 8'h3C; in_b[0] = 8'h44; in_cin[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    errm[0] = 0; errm[1] = 0;
    check_reset_state(0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid[0]), 0);
    end

    stream(1, 256);
    stream(0, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
